// File: rtl/common_pkg.sv
// Shared types and helpers for the multiexp front end.
// Holds the default field widths and the pass-count helper used to size the
// scalar window replay.
package common_pkg;

   // Default field widths: one field element, and a Jacobian point of three
   // field elements.
   localparam int unsigned FE_BITS       = 256;
   localparam int unsigned JB_POINT_BITS = 3 * FE_BITS;

   // Number of window passes needed to cover a scalar of scl_bits.
   function automatic int unsigned win_passes(input int unsigned scl_bits,
                                              input int unsigned win_bits);
      return (scl_bits + win_bits - 1) / win_bits;
   endfunction

endpackage

// File: rtl/multiexp_replay_buf.sv
// Batch buffer for the point/scalar replay: DEPTH x DAT_BITS storage with one
// write port and one registered read port.
// Ports:
//   clk                  clock
//   wr_en/wr_addr/wr_dat write port
//   rd_en/rd_addr        read request; rd_dat updates only when rd_en is high
//   rd_dat               registered read data
//   rd_scl_c             scalar field of the word rd_dat is about to load
//                        (combinational look-ahead)
// A write to the address being read is forwarded, so a word can be read back
// on the same edge it is written.
module multiexp_replay_buf #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned DAT_BITS = 16,
   parameter int unsigned SCL_BITS = 8,
   parameter int unsigned ADDR_W   = 1
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DAT_BITS-1:0] wr_dat,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DAT_BITS-1:0] rd_dat,
   output logic [SCL_BITS-1:0] rd_scl_c
);

   logic [DAT_BITS-1:0] mem [DEPTH];
   logic [DAT_BITS-1:0] rd_peek;

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   // Write-through forwarding onto the read path.
   always_comb begin
      rd_peek = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_peek = wr_dat;
      end
   end

   assign rd_scl_c = rd_peek[SCL_BITS-1:0];

   // Registered read port, holds while rd_en is low.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_dat <= rd_peek;
      end
   end

endmodule

// File: rtl/multiexp_pnt_scl_replay.sv
// Point/scalar replay front end for the multiexp core.
// Loads a batch of up to NUM_IN {point, scalar} beats, then replays the batch
// once per scalar window, MSB window first, tagging each beat with the
// current window value and pass index.
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_pnt_scl_dat/val/eop   input stream; eop closes a short batch
//   i_pnt_scl_rdy           input ready (high only while loading)
//   o_pnt_scl_dat/val/rdy   replayed stream
//   o_pnt_scl_sop/eop       first / last beat of the whole replay
//   o_pnt_scl_ctl           entry index within the batch
//   o_win                   scalar window of the current output beat
//   o_pass                  pass index, counting down to 0
//   o_busy                  high while replaying
module multiexp_pnt_scl_replay
   import common_pkg::*;
#(
   parameter int unsigned SCL_BITS = FE_BITS,
   parameter int unsigned DAT_BITS = FE_BITS + JB_POINT_BITS,
   parameter int unsigned NUM_IN   = 2,
   parameter int unsigned WIN_BITS = 1,
   parameter int unsigned CTL_BITS = 8
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic [DAT_BITS-1:0]                           i_pnt_scl_dat,
   input  logic                                          i_pnt_scl_val,
   input  logic                                          i_pnt_scl_eop,
   output logic                                          i_pnt_scl_rdy,
   output logic [DAT_BITS-1:0]                           o_pnt_scl_dat,
   output logic                                          o_pnt_scl_val,
   input  logic                                          o_pnt_scl_rdy,
   output logic                                          o_pnt_scl_sop,
   output logic                                          o_pnt_scl_eop,
   output logic [CTL_BITS-1:0]                           o_pnt_scl_ctl,
   output logic [WIN_BITS-1:0]                           o_win,
   output logic [$clog2(win_passes(SCL_BITS, WIN_BITS)):0] o_pass,
   output logic                                          o_busy
);

   localparam int unsigned PASSES   = win_passes(SCL_BITS, WIN_BITS);
   localparam int unsigned PASS_W   = $clog2(PASSES) + 1;
   localparam int unsigned PAD_BITS = PASSES * WIN_BITS;
   localparam int unsigned IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int unsigned CNT_W    = $clog2(NUM_IN + 1);
   localparam logic [PASS_W-1:0] PASS_TOP = PASS_W'(PASSES - 1);

   typedef enum logic {
      ST_LOAD,
      ST_REPLAY
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;

   logic                in_acc;
   logic                out_acc;
   logic                in_last;
   logic                idx_wrap;
   logic [IDX_W-1:0]    idx_nxt;
   logic [PASS_W-1:0]   pass_nxt;
   logic [IDX_W-1:0]    rd_addr;
   logic                rd_en;
   logic [SCL_BITS-1:0] rd_scl;

   // Window p of a scalar; bits above SCL_BITS read as zero.
   function automatic logic [WIN_BITS-1:0] scl_win(input logic [SCL_BITS-1:0] scl,
                                                   input logic [PASS_W-1:0]   p);
      logic [PAD_BITS-1:0] padded;
      padded = PAD_BITS'(scl);
      return WIN_BITS'(padded >> (int'(p) * WIN_BITS));
   endfunction

   // Handshakes and next replay position.
   always_comb begin
      in_acc   = (state == ST_LOAD) && i_pnt_scl_rdy && i_pnt_scl_val;
      out_acc  = (state == ST_REPLAY) && o_pnt_scl_val && o_pnt_scl_rdy;
      in_last  = i_pnt_scl_eop || (cnt == CNT_W'(NUM_IN - 1));
      idx_wrap = (CNT_W'(idx) + CNT_W'(1)) == cnt;
      idx_nxt  = idx_wrap ? '0 : idx + IDX_W'(1);
      pass_nxt = idx_wrap ? o_pass - PASS_W'(1) : o_pass;
      // Loading keeps entry 0 prefetched; replay reads ahead one beat.
      rd_addr  = (state == ST_REPLAY) ? idx_nxt : '0;
      rd_en    = (state == ST_LOAD) || out_acc;
   end

   multiexp_replay_buf #(
      .DEPTH    (NUM_IN),
      .DAT_BITS (DAT_BITS),
      .SCL_BITS (SCL_BITS),
      .ADDR_W   (IDX_W)
   ) u_buf (
      .clk      (i_clk),
      .wr_en    (in_acc),
      .wr_addr  (IDX_W'(cnt)),
      .wr_dat   (i_pnt_scl_dat),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_dat   (o_pnt_scl_dat),
      .rd_scl_c (rd_scl)
   );

   assign o_pnt_scl_ctl = CTL_BITS'(idx);

   // Load/replay control, counters and output tags.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= ST_LOAD;
         cnt           <= '0;
         idx           <= '0;
         o_pass        <= '0;
         o_win         <= '0;
         i_pnt_scl_rdy <= 1'b1;
         o_pnt_scl_val <= 1'b0;
         o_pnt_scl_sop <= 1'b0;
         o_pnt_scl_eop <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_acc) begin
                  cnt <= cnt + CNT_W'(1);
                  if (in_last) begin
                     // First replay beat is presented straight away.
                     state         <= ST_REPLAY;
                     i_pnt_scl_rdy <= 1'b0;
                     o_busy        <= 1'b1;
                     o_pnt_scl_val <= 1'b1;
                     o_pnt_scl_sop <= 1'b1;
                     o_pnt_scl_eop <= (PASS_TOP == '0) && (cnt == '0);
                     idx           <= '0;
                     o_pass        <= PASS_TOP;
                     o_win         <= scl_win(rd_scl, PASS_TOP);
                  end
               end
            end
            ST_REPLAY: begin
               if (out_acc) begin
                  if (o_pnt_scl_eop) begin
                     state         <= ST_LOAD;
                     cnt           <= '0;
                     idx           <= '0;
                     o_pass        <= '0;
                     o_win         <= '0;
                     i_pnt_scl_rdy <= 1'b1;
                     o_pnt_scl_val <= 1'b0;
                     o_pnt_scl_sop <= 1'b0;
                     o_pnt_scl_eop <= 1'b0;
                     o_busy        <= 1'b0;
                  end else begin
                     idx           <= idx_nxt;
                     o_pass        <= pass_nxt;
                     o_pnt_scl_sop <= 1'b0;
                     o_pnt_scl_eop <= (pass_nxt == '0) &&
                                      ((CNT_W'(idx_nxt) + CNT_W'(1)) == cnt);
                     o_win         <= scl_win(rd_scl, pass_nxt);
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_multiexp_pnt_scl_replay.sv
// Directed bench for multiexp_pnt_scl_replay.
// Four configurations share the input stream; sel picks which one is driven
// and observed.  g0: SCL8/WIN4/N2, g1: SCL8/WIN1/N2, g2: SCL8/WIN4/N4,
// g3: SCL10/WIN4/N2.  Beat payload is 16 bits, scalar in the low bits.
module tb_multiexp_pnt_scl_replay;
   import common_pkg::*;

   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_dat;
   logic          in_eop;
   logic [3:0]    in_val;
   logic          out_rdy;
   logic [1:0]    sel;

   int n_chk;
   int n_bad;

   logic [3:0]    rdy_v, val_v, sop_v, eop_v, busy_v;
   logic [DW-1:0] dat_v  [4];
   logic [7:0]    ctl_v  [4];
   logic [7:0]    win_v  [4];
   logic [7:0]    pass_v [4];

   logic [63:0]   r_beat [32];
   logic [63:0]   e_beat [32];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned SB = (g == 3) ? 10 : 8;
      localparam int unsigned WB = (g == 1) ? 1 : 4;
      localparam int unsigned NI = (g == 2) ? 4 : 2;
      localparam int unsigned PW = $clog2(win_passes(SB, WB)) + 1;

      logic [WB-1:0] win;
      logic [PW-1:0] pass;
      logic [7:0]    ctl;
      logic [DW-1:0] dat;
      logic          rdy, val, sop, eop, busy;

      multiexp_pnt_scl_replay #(
         .SCL_BITS (SB),
         .DAT_BITS (DW),
         .NUM_IN   (NI),
         .WIN_BITS (WB),
         .CTL_BITS (8)
      ) u_dut (
         .i_clk         (clk),
         .i_rst         (rst_n),
         .i_pnt_scl_dat (in_dat),
         .i_pnt_scl_val (in_val[g]),
         .i_pnt_scl_eop (in_eop),
         .i_pnt_scl_rdy (rdy),
         .o_pnt_scl_dat (dat),
         .o_pnt_scl_val (val),
         .o_pnt_scl_rdy (out_rdy),
         .o_pnt_scl_sop (sop),
         .o_pnt_scl_eop (eop),
         .o_pnt_scl_ctl (ctl),
         .o_win         (win),
         .o_pass        (pass),
         .o_busy        (busy)
      );

      assign rdy_v[g]  = rdy;
      assign val_v[g]  = val;
      assign sop_v[g]  = sop;
      assign eop_v[g]  = eop;
      assign busy_v[g] = busy;
      assign dat_v[g]  = dat;
      assign ctl_v[g]  = ctl;
      assign win_v[g]  = 8'(win);
      assign pass_v[g] = 8'(pass);
   end

   logic          obs_rdy, obs_val, obs_sop, obs_eop, obs_busy;
   logic [DW-1:0] obs_dat;
   logic [7:0]    obs_ctl, obs_win, obs_pass;

   assign obs_rdy  = rdy_v[sel];
   assign obs_val  = val_v[sel];
   assign obs_sop  = sop_v[sel];
   assign obs_eop  = eop_v[sel];
   assign obs_busy = busy_v[sel];
   assign obs_dat  = dat_v[sel];
   assign obs_ctl  = ctl_v[sel];
   assign obs_win  = win_v[sel];
   assign obs_pass = pass_v[sel];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected beat packed as {dat, ctl, pass, win, sop, eop}.
   task automatic set_exp(input int i, input logic [DW-1:0] d, input int c,
                          input int p, input int w, input bit s, input bit e);
      e_beat[i] = 64'({d, 8'(c), 8'(p), 8'(w), s, e});
   endtask

   // Called at a negedge; presents one beat once rdy is seen.
   task automatic send_beat(input logic [DW-1:0] d, input logic e);
      int t;
      t = 0;
      while (!obs_rdy && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk("in_rdy", 64'(obs_rdy), 64'd1);
      in_dat      = d;
      in_eop      = e;
      in_val[sel] = 1'b1;
      @(negedge clk);
      in_val = '0;
      in_eop = 1'b0;
   endtask

   // Called at a negedge; collects nb accepted beats, optional backpressure.
   task automatic recv(input int nb, input bit bp);
      int          got;
      int          cyc;
      logic        stall;
      logic [63:0] prev;
      logic [63:0] cur;
      got   = 0;
      cyc   = 0;
      stall = 1'b0;
      prev  = '0;
      while (got < nb && cyc < 400) begin
         cur = 64'({obs_val, obs_dat, obs_ctl, obs_pass, obs_win, obs_sop, obs_eop});
         if (stall) chk("hold", cur, prev);
         chk("busy_rdy", 64'({obs_busy, obs_rdy}), 64'd2);
         out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (obs_val && out_rdy) begin
            r_beat[got] = 64'({obs_dat, obs_ctl, obs_pass, obs_win, obs_sop, obs_eop});
            got++;
         end
         stall = obs_val && !out_rdy;
         prev  = cur;
         @(negedge clk);
         cyc++;
      end
      out_rdy = 1'b1;
      chk("beat_cnt", 64'(got), 64'(nb));
   endtask

   task automatic cmp_seq(input string tag, input int nb);
      for (int i = 0; i < nb; i++) begin
         chk($sformatf("%s_b%0d", tag, i), r_beat[i], e_beat[i]);
      end
   endtask

   // After the eop beat is taken: ready again, no output, not busy.
   task automatic idle_chk(input string tag);
      chk(tag, 64'({obs_rdy, obs_val, obs_busy}), 64'd4);
   endtask

   task automatic exp_s1();
      set_exp(0, 16'h12A5, 0, 1, 4'hA, 1'b1, 1'b0);
      set_exp(1, 16'h343C, 1, 1, 4'h3, 1'b0, 1'b0);
      set_exp(2, 16'h12A5, 0, 0, 4'h5, 1'b0, 1'b0);
      set_exp(3, 16'h343C, 1, 0, 4'hC, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      in_dat  = '0;
      in_eop  = 1'b0;
      in_val  = '0;
      out_rdy = 1'b1;
      sel     = 2'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state of every configuration: rdy=1, everything else 0.
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         #1;
         chk($sformatf("rst_state%0d", i),
             64'({obs_rdy, obs_val, obs_busy, obs_sop, obs_eop, obs_pass, obs_win}),
             64'h10_0000);
      end
      @(negedge clk);

      // Two entries, 4-bit windows over 8-bit scalars.
      sel = 2'd0;
      send_beat(16'h12A5, 1'b0);
      send_beat(16'h343C, 1'b0);
      chk("s1_lat", 64'({obs_val, obs_rdy}), 64'd2);
      recv(4, 1'b0);
      exp_s1();
      cmp_seq("s1", 4);
      idle_chk("s1_idle");

      // Bit-serial: 8 passes over two entries.
      sel = 2'd1;
      send_beat(16'h1180, 1'b0);
      send_beat(16'h2201, 1'b0);
      recv(16, 1'b0);
      for (int i = 0; i < 16; i++) begin
         int p;
         int k;
         p = 7 - i / 2;
         k = i % 2;
         set_exp(i, (k == 0) ? 16'h1180 : 16'h2201, k, p,
                 (k == 0) ? int'(p == 7) : int'(p == 0), i == 0, i == 15);
      end
      cmp_seq("s2", 16);
      idle_chk("s2_idle");

      // Short batch: single eop beat into a depth-4 buffer.
      sel = 2'd2;
      send_beat(16'h5503, 1'b1);
      chk("s3_lat", 64'({obs_val, obs_rdy}), 64'd2);
      recv(2, 1'b0);
      set_exp(0, 16'h5503, 0, 1, 4'h0, 1'b1, 1'b0);
      set_exp(1, 16'h5503, 0, 0, 4'h3, 1'b0, 1'b1);
      cmp_seq("s3", 2);
      idle_chk("s3_idle");

      // 10-bit scalar, top window zero padded.
      sel = 2'd3;
      send_beat(16'hA7FF, 1'b1);
      recv(3, 1'b0);
      set_exp(0, 16'hA7FF, 0, 2, 4'h3, 1'b1, 1'b0);
      set_exp(1, 16'hA7FF, 0, 1, 4'hF, 1'b0, 1'b0);
      set_exp(2, 16'hA7FF, 0, 0, 4'hF, 1'b0, 1'b1);
      cmp_seq("s4", 3);
      idle_chk("s4_idle");

      // First scenario again under random output backpressure.
      sel = 2'd0;
      send_beat(16'h12A5, 1'b0);
      send_beat(16'h343C, 1'b0);
      recv(4, 1'b1);
      exp_s1();
      cmp_seq("s5", 4);
      idle_chk("s5_idle");

      // Reset after two replayed beats, then a fresh batch.
      send_beat(16'h12A5, 1'b0);
      send_beat(16'h343C, 1'b0);
      recv(2, 1'b0);
      exp_s1();
      cmp_seq("s6a", 2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("s6_rst_out", 64'({obs_val, obs_busy}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      idle_chk("s6_rel");
      send_beat(16'h7781, 1'b0);
      send_beat(16'h99F0, 1'b0);
      recv(4, 1'b0);
      set_exp(0, 16'h7781, 0, 1, 4'h8, 1'b1, 1'b0);
      set_exp(1, 16'h99F0, 1, 1, 4'hF, 1'b0, 1'b0);
      set_exp(2, 16'h7781, 0, 0, 4'h1, 1'b0, 1'b0);
      set_exp(3, 16'h99F0, 1, 0, 4'h0, 1'b0, 1'b1);
      cmp_seq("s6b", 4);
      idle_chk("s6_idle");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
